y_stepper: RTL and testbench
============================

# y_stepper

Drives the load side of the game's vertical position register: on each level-advance request it moves the active block upward from its current row by exactly one block height. Each one-pixel move is a single-cycle `load` strobe with `new_y_position`, paced by an internal tick divider, so the VGA renderer sees a smooth climb. It sits between the game FSM (`start`/`done`/`busy`/`at_top`) and the y position register (`load`/`new_y_position`).

## Interface
- `Y_INIT`, 7'd104: bottom row, the position after reset.
- `UNIT_BLOCK`, 5'd16: block height in pixels; one level advance = this many 1-pixel steps.
- `Y_MIN`, 7'd8: topmost legal row; a request that would go above it is refused.
- `STEP_DIV`, 833333: clocks per 1-pixel step (50 MHz / 60 Hz); legal range 2 to 2^20-1.
- `clk`  in  1  50 MHz system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle request to advance one level; sampled only in IDLE.
- `load`  out  1  single-cycle strobe to the position register.
- `new_y_position`  out  7  value to load; valid whenever `load`=1, otherwise holds the shadow y.
- `busy`  out  1  high in MOVE.
- `done`  out  1  single-cycle pulse when a level advance completes.
- `at_top`  out  1  sticky; set when a request is refused because the target is above `Y_MIN`.

## Operation
- Internal shadow register `y_shadow[6:0]` mirrors the position register. No read-back path exists, so the register must be loaded only by this block.
- Reset values: `y_shadow`=Y_INIT, state IDLE, `load`=0, `done`=0, `busy`=0, `at_top`=0, divider=0, step count=0, `new_y_position`=Y_INIT.
- States:
  - IDLE
    - On `start`, compute target = `y_shadow` − UNIT_BLOCK in 8-bit signed arithmetic.
    - If target < Y_MIN: set `at_top` and stay in IDLE. No `load` and no `done` are issued.
    - Otherwise: clear the divider, set step count to UNIT_BLOCK, and go to MOVE.
  - MOVE
    - The divider counts 0 to STEP_DIV−1. On the wrap cycle: `y_shadow` decrements by 1, `load`=1, `new_y_position`=decremented value, and step count decrements.
    - When step count reaches 0 on a wrap, go to DONE.
  - DONE
    - Assert `done` for one cycle, then return to IDLE.
- Boundary conditions:
  - `start` in MOVE or DONE is ignored; nothing is queued.
  - `at_top` clears only on `reset`.
  - Target exactly equal to Y_MIN is legal.
  - `y_shadow` never wraps; the target check guarantees this.
  - `reset` mid-MOVE aborts immediately to reset values. No further `load` is issued, and the position register must also be reset by the same `reset`.

## Timing
- `load` and `new_y_position` are registered outputs. The position register captures them at the next `clk` edge.
- Latency from `start` (sampled at edge N) to the first `load`: high at edge N+STEP_DIV.
- Consecutive `load` strobes are exactly STEP_DIV cycles apart. A full advance takes 16 strobes.
- `done` is high during the cycle after the final `load` (edge N+16·STEP_DIV+1). `busy` drops in that same cycle.
- Earliest accepted next `start` is the cycle after `done`.
- A refused `start` sets `at_top` on the next edge.

## Configuration
- `Y_STEPPER_INSTANT_EN` defined:
  - MOVE takes exactly one cycle, with no divider.
  - A single `load` carries the target directly (`y_shadow` − UNIT_BLOCK).
  - `done` follows on the next cycle.
  - The divider logic is not compiled.
- Undefined: the animated 16-step behaviour above.

## Structure
- Shared package `tower_pkg`:
  - Constants `Y_INIT`, `UNIT_BLOCK`, `Y_MIN`, `Y_WIDTH`=7.
  - The 2-bit state enum `y_step_state_t` (IDLE, MOVE, DONE).
- Submodule `step_tick`:
  - Parameterised divider with a clear input and a single-cycle `tick` output on wrap.
  - Reused by the x-axis mover.

## Test plan
All scenarios use STEP_DIV=4 for simulation.
- Reset, then 5 idle cycles → `load`=0, `new_y_position`=104, `busy`=0, `at_top`=0.
- `start` pulse → 16 `load` strobes 4 cycles apart with values 103 down to 88, first at +4 cycles; `done` 1 cycle after the last strobe; `busy` high throughout.
- 6 consecutive advances from 104 (y=8 after the sixth) → 7th `start` is refused: `at_top`=1, no `load`, no `done`, y remains 8.
- `start` re-asserted mid-MOVE and in the DONE cycle → ignored; exactly 16 strobes total and one `done`.
- `reset` asserted asynchronously between strobes 7 and 8 → outputs return to reset values immediately with no further strobes; a following `start` climbs 104→88.
- With `Y_STEPPER_INSTANT_EN` defined: `start` → one `load` with value 88 one cycle later, `done` on the following cycle.

Source files
------------

// File: rtl/tower_pkg.sv
// Shared constants and state encoding for the tower game's position movers.
package tower_pkg;

  localparam int Y_WIDTH   = 7;
  localparam int DIV_WIDTH = 20;

  localparam logic [Y_WIDTH-1:0] Y_INIT     = 7'd104;
  localparam logic [4:0]         UNIT_BLOCK = 5'd16;
  localparam logic [Y_WIDTH-1:0] Y_MIN      = 7'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DONE = 2'd2
  } y_step_state_t;

endpackage

// File: rtl/y_stepper_if.sv
// Request/status and position-load signals between game FSM, y_stepper and the y register.
// Handshake: start is a one-cycle request honoured only while busy=0 and done=0;
// load is a one-cycle strobe, new_y_position is valid whenever load=1.
interface y_stepper_if;
  import tower_pkg::*;

  logic               start;
  logic               load;
  logic [Y_WIDTH-1:0] new_y_position;
  logic               busy;
  logic               done;
  logic               at_top;

  modport master (
    output start,
    input  load,
    input  new_y_position,
    input  busy,
    input  done,
    input  at_top
  );

  modport slave (
    input  start,
    output load,
    output new_y_position,
    output busy,
    output done,
    output at_top
  );

endinterface

// File: rtl/step_tick.sv
// Free-running divider that emits a one-cycle tick every DIV enabled clocks.
// Shared by the x- and y-axis movers; clear restarts the count from zero.
module step_tick #(
  parameter int unsigned DIV = 4,
  parameter int          W   = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/y_stepper.sv
// Moves the active block up one block height as a paced series of 1-pixel loads.
// Define Y_STEPPER_INSTANT_EN to replace the animated climb with a single jump.
module y_stepper
  import tower_pkg::*;
#(
  parameter int unsigned STEP_DIV = 833333
) (
  input  logic          clk,
  input  logic          reset,
  y_stepper_if.slave    bus,
  output y_step_state_t dbg_state
);

  y_step_state_t      state;
  logic [Y_WIDTH-1:0] y_shadow;
  logic [Y_WIDTH-1:0] new_y;
  logic [4:0]         step_cnt;
  logic               load_r;
  logic               done_r;
  logic               busy_r;
  logic               at_top_r;

  logic signed [7:0]  target;
  logic               refuse;
  logic               accept;

  // Signed so a target above row 0 shows up as negative rather than wrapping.
  assign target = $signed({1'b0, y_shadow}) - $signed({3'b000, UNIT_BLOCK});
  assign refuse = target < $signed({1'b0, Y_MIN});
  assign accept = (state == IDLE) && bus.start && !refuse;

`ifndef Y_STEPPER_INSTANT_EN
  logic tick;

  step_tick #(
    .DIV (STEP_DIV),
    .W   (DIV_WIDTH)
  ) u_step_tick (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .en    ((state == MOVE) && (step_cnt != 5'd0)),
    .tick  (tick)
  );
`endif

  // MOVE lingers one cycle after the last load so DONE covers exactly the done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      y_shadow <= Y_INIT;
      new_y    <= Y_INIT;
      step_cnt <= 5'd0;
      load_r   <= 1'b0;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
      at_top_r <= 1'b0;
    end else begin
      load_r <= 1'b0;
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && refuse) begin
            at_top_r <= 1'b1;
          end else if (accept) begin
            state  <= MOVE;
            busy_r <= 1'b1;
`ifdef Y_STEPPER_INSTANT_EN
            step_cnt <= 5'd1;
`else
            step_cnt <= UNIT_BLOCK;
`endif
          end
        end
        MOVE: begin
          if (step_cnt == 5'd0) begin
            state  <= DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end else begin
`ifdef Y_STEPPER_INSTANT_EN
            load_r   <= 1'b1;
            y_shadow <= target[Y_WIDTH-1:0];
            new_y    <= target[Y_WIDTH-1:0];
            step_cnt <= 5'd0;
`else
            if (tick) begin
              load_r   <= 1'b1;
              y_shadow <= y_shadow - 7'd1;
              new_y    <= y_shadow - 7'd1;
              step_cnt <= step_cnt - 5'd1;
            end
`endif
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.load           = load_r;
  assign bus.new_y_position = new_y;
  assign bus.busy           = busy_r;
  assign bus.done           = done_r;
  assign bus.at_top         = at_top_r;
  assign dbg_state          = state;

endmodule

// File: tb/tb_y_stepper.sv
// Directed bench for y_stepper with STEP_DIV=4; load values tracked through an expected queue.
module tb_y_stepper;
  import tower_pkg::*;

  localparam int DIV = 4;

  logic          clk;
  logic          reset;
  y_step_state_t dbg_state;

  y_stepper_if bus ();

  y_stepper #(.STEP_DIV(DIV)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad    = 0;
  int cyc      = 0;
  int load_cnt = 0;
  int done_cnt = 0;
  int first_load_cyc = -1;
  int last_load_cyc  = -1;
  logic [6:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // scoreboard: every strobe must match the next expected row and be DIV cycles after the last
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.load) begin
        load_cnt++;
        if (exp_q.size() == 0) check("load_unexpected", 32'd1, 32'd0);
        else check("load_val", {25'd0, bus.new_y_position}, {25'd0, exp_q.pop_front()});
        if (last_load_cyc >= 0) check("load_gap", cyc - last_load_cyc, DIV);
        else first_load_cyc = cyc;
        last_load_cyc = cyc;
      end
      if (bus.done) done_cnt++;
    end
  end

  // driver tasks
  task automatic pulse_start();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
  endtask

  task automatic idle_quiet(input int n);
    int l0, d0;
    l0 = load_cnt;
    d0 = done_cnt;
    repeat (n) @(negedge clk);
    check("quiet_loads", load_cnt - l0, 0);
    check("quiet_dones", done_cnt - d0, 0);
  endtask

`ifndef Y_STEPPER_INSTANT_EN
  task automatic do_advance(input int from_y, input bit poke);
    int n0, d0, t0;
    bit seen;
    for (int i = 1; i <= 16; i++) exp_q.push_back(7'(from_y - i));
    last_load_cyc  = -1;
    first_load_cyc = -1;
    n0 = load_cnt;
    d0 = done_cnt;
    pulse_start();
    t0 = cyc;
    check("busy_start", bus.busy, 1);
    seen = 1'b0;
    for (int k = 0; k < 120 && !seen; k++) begin
      @(negedge clk);
      bus.start = poke && (k == 10);
      if (k == 30) check("busy_mid", bus.busy, 1);
      if (bus.done) seen = 1'b1;
    end
    bus.start = 1'b0;
    if (!seen) check("done_timeout", 0, 1);
    check("done_time", cyc - t0, 16 * DIV + 1);
    check("busy_at_done", bus.busy, 0);
    if (poke) bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("done_width", bus.done, 0);
    check("strobes", load_cnt - n0, 16);
    check("done_count", done_cnt - d0, 1);
    check("first_latency", first_load_cyc - t0, DIV);
    check("exp_q_empty", exp_q.size(), 0);
    check("y_after", bus.new_y_position, from_y - 16);
    if (poke) idle_quiet(80);
  endtask
`else
  task automatic do_instant();
    int t0;
    bit seen;
    exp_q.push_back(7'd88);
    last_load_cyc  = -1;
    first_load_cyc = -1;
    pulse_start();
    t0 = cyc;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    if (!seen) check("done_timeout", 0, 1);
    check("inst_load_lat", first_load_cyc - t0, 1);
    check("inst_done_lat", cyc - t0, 2);
    check("inst_y", bus.new_y_position, 88);
    check("inst_exp_q_empty", exp_q.size(), 0);
    idle_quiet(10);
  endtask
`endif

  initial begin
    int n0;
    reset     = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_load", bus.load, 0);
    check("rst_y", bus.new_y_position, 104);
    check("rst_busy", bus.busy, 0);
    check("rst_at_top", bus.at_top, 0);
    check("rst_done", bus.done, 0);
    check("rst_state", dbg_state, IDLE);

`ifndef Y_STEPPER_INSTANT_EN
    do_advance(104, 1'b0);
    do_advance(88, 1'b1);
    do_advance(72, 1'b0);
    do_advance(56, 1'b0);
    do_advance(40, 1'b0);
    do_advance(24, 1'b0);

    // seventh request from row 8 would go above Y_MIN
    pulse_start();
    check("top_at_top", bus.at_top, 1);
    check("top_busy", bus.busy, 0);
    idle_quiet(80);
    check("top_y", bus.new_y_position, 8);
    check("top_sticky", bus.at_top, 1);

    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    check("rst2_at_top", bus.at_top, 0);
    check("rst2_y", bus.new_y_position, 104);

    // abort a climb between strobes 7 and 8
    for (int i = 1; i <= 16; i++) exp_q.push_back(7'(104 - i));
    last_load_cyc = -1;
    n0 = load_cnt;
    pulse_start();
    for (int k = 0; k < 200; k++) begin
      if (load_cnt - n0 >= 7) break;
      @(negedge clk);
    end
    check("abort_reach7", load_cnt - n0, 7);
    @(negedge clk);
    #3 reset = 1'b1;
    #1;
    check("abort_load", bus.load, 0);
    check("abort_y", bus.new_y_position, 104);
    check("abort_busy", bus.busy, 0);
    check("abort_state", dbg_state, IDLE);
    exp_q.delete();
    @(negedge clk) reset = 1'b0;
    idle_quiet(30);
    do_advance(104, 1'b0);
`else
    do_instant();
`endif

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
